// File: rtl/pong_physics_if.sv
// pong_physics_if: signal bundle between the game control / keypad side and the
// pong_physics motion engine.
//   master : game side, drives stop, paddle keys and speed_up; receives positions/misses
//   slave  : pong_physics side
// Signals:
//   stop                       1 = freeze play
//   up1, down1, up2, down2     level paddle commands
//   speed_up                   one-cycle pulse, raises ball speed level
//   ball_x, ball_y             top-left pixel of the 8x8 ball
//   paddle1_y, paddle2_y       top pixel of each 8x64 paddle
//   miss1, miss2               one-cycle pulse, player 1 / player 2 missed
interface pong_physics_if;
  logic       stop;
  logic       up1;
  logic       down1;
  logic       up2;
  logic       down2;
  logic       speed_up;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic       miss1;
  logic       miss2;

  modport master (
    output stop, up1, down1, up2, down2, speed_up,
    input  ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2
  );

  modport slave (
    input  stop, up1, down1, up2, down2, speed_up,
    output ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2
  );
endinterface

// File: rtl/pong_physics.sv
// pong_physics: ball and paddle motion engine for a 640x480 Pong field.
// Advances ball and paddles on an internal movement tick, resolves wall and
// paddle collisions, and pulses miss1/miss2 when the ball passes a paddle.
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   pong_physics_if.slave (stop, keys, speed_up in; positions, misses out)
// Parameters:
//   TICK_DIV     clk cycles per movement tick (>= 2)
//   PADDLE_STEP  pixels a paddle moves per tick
//   SPEED_MAX    highest speed level; ball step = 1 + level per axis per tick
// Build option:
//   PONG_AI_P2_EN  when defined, paddle 2 tracks the ball and ignores up2/down2.
module pong_physics #(
  parameter int TICK_DIV    = 500000,
  parameter int PADDLE_STEP = 4,
  parameter int SPEED_MAX   = 3
) (
  input logic           clk,
  input logic           rst,
  pong_physics_if.slave bus
);
  localparam int            CW       = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int            LW       = (SPEED_MAX < 1) ? 1 : $clog2(SPEED_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LVL_MAX  = LW'(SPEED_MAX);
  localparam logic [9:0]    CTR_X    = 10'd316;
  localparam logic [9:0]    CTR_Y    = 10'd236;
  localparam logic [9:0]    PAD_INIT = 10'd208;

  typedef enum logic [1:0] {SERVE, RUN, MISS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] run_cnt, free_cnt;
  logic [LW-1:0] level;
  logic [9:0]    bx, by, p1, p2;
  logic          dx_neg, dy_neg;
  logic          miss1_q, miss2_q;

  logic               run_tick, free_tick, pad_tick;
  logic signed [10:0] step, bx_s, by_s, nx, ny;
  logic               ov1, ov2, l_bounce, l_miss, r_bounce, r_miss;
  logic [9:0]         nbx, nby, p1_next, p2_next;
  logic               ndx_neg, ndy_neg, up2_eff, down2_eff;

  // Paddle step with clamp to the 0..416 travel range; opposing keys cancel.
  function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up,
                                          input logic down);
    logic signed [11:0] t;
    t = $signed({2'b00, y});
    if (up && !down)      t = t - 12'(PADDLE_STEP);
    else if (down && !up) t = t + 12'(PADDLE_STEP);
    if (t < 12'sd0)        t = 12'sd0;
    else if (t > 12'sd416) t = 12'sd416;
    return t[9:0];
  endfunction

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    run_tick  = (state_q == RUN) && !bus.stop && (run_cnt == CNT_LAST);
    free_tick = (free_cnt == CNT_LAST);
    // Paddles follow the play tick in RUN and a free-running tick while serving.
    pad_tick  = run_tick || ((state_q == SERVE) && free_tick);

    step = 11'(level) + 11'sd1;
    bx_s = $signed({1'b0, bx});
    by_s = $signed({1'b0, by});
    nx   = dx_neg ? (bx_s - step) : (bx_s + step);
    ny   = dy_neg ? (by_s - step) : (by_s + step);

    // Overlap uses paddle positions from before this tick.
    ov1 = (by_s + 11'sd8 > $signed({1'b0, p1})) && (by_s < $signed({1'b0, p1}) + 11'sd64);
    ov2 = (by_s + 11'sd8 > $signed({1'b0, p2})) && (by_s < $signed({1'b0, p2}) + 11'sd64);

    l_bounce = dx_neg && (bx_s >= 11'sd24) && (nx < 11'sd24) && ov1;
    l_miss   = !l_bounce && (nx <= 11'sd0);
    r_bounce = !dx_neg && (bx_s <= 11'sd608) && (nx > 11'sd608) && ov2;
    r_miss   = !r_bounce && (nx >= 11'sd632);

    nbx     = nx[9:0];
    ndx_neg = dx_neg;
    if (l_bounce) begin
      nbx     = 10'd24;
      ndx_neg = 1'b0;
    end else if (r_bounce) begin
      nbx     = 10'd608;
      ndx_neg = 1'b1;
    end else if (l_miss) begin
      nbx = 10'd0;
    end else if (r_miss) begin
      nbx = 10'd632;
    end

    nby     = ny[9:0];
    ndy_neg = dy_neg;
    if (ny <= 11'sd0) begin
      nby     = 10'd0;
      ndy_neg = 1'b0;
    end else if (ny >= 11'sd472) begin
      nby     = 10'd472;
      ndy_neg = 1'b1;
    end

`ifdef PONG_AI_P2_EN
    // Track so the paddle centre lines up with the ball centre (ball_y - 28).
    up2_eff   = $signed({1'b0, p2}) > (by_s - 11'sd28);
    down2_eff = $signed({1'b0, p2}) < (by_s - 11'sd28);
`else
    up2_eff   = bus.up2;
    down2_eff = bus.down2;
`endif
    p1_next = pad_next(p1, bus.up1, bus.down1);
    p2_next = pad_next(p2, up2_eff, down2_eff);

    state_d = state_q;
    case (state_q)
      SERVE:   if (!bus.stop) state_d = RUN;
      RUN:     if (run_tick && (l_miss || r_miss)) state_d = MISS;
      MISS:    if (bus.stop) state_d = SERVE;
      default: state_d = SERVE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every
  // always_ff sees the pre-edge values of the others, matching hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SERVE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt  <= '0;
      free_cnt <= '0;
      level    <= '0;
      bx       <= CTR_X;
      by       <= CTR_Y;
      dx_neg   <= 1'b0;
      dy_neg   <= 1'b0;
      p1       <= PAD_INIT;
      p2       <= PAD_INIT;
      miss1_q  <= 1'b0;
      miss2_q  <= 1'b0;
    end else begin
      free_cnt <= (free_cnt == CNT_LAST) ? '0 : free_cnt + CW'(1);
      // Holding the count while paused lets play resume mid-period.
      if ((state_q == RUN) && !bus.stop)
        run_cnt <= (run_cnt == CNT_LAST) ? '0 : run_cnt + CW'(1);
      if (bus.speed_up && (level != LVL_MAX))
        level <= level + LW'(1);
      if (pad_tick) begin
        p1 <= p1_next;
        p2 <= p2_next;
      end
      miss1_q <= run_tick && l_miss;
      miss2_q <= run_tick && r_miss;
      if (run_tick) begin
        bx     <= nbx;
        by     <= nby;
        dx_neg <= ndx_neg;
        dy_neg <= ndy_neg;
      end else if ((state_q == MISS) && bus.stop) begin
        // dx still points at the side that missed, so the serve heads there.
        bx <= CTR_X;
        by <= CTR_Y;
      end
    end
  end

  assign bus.ball_x    = bx;
  assign bus.ball_y    = by;
  assign bus.paddle1_y = p1;
  assign bus.paddle2_y = p2;
  assign bus.miss1     = miss1_q;
  assign bus.miss2     = miss2_q;
endmodule

// File: tb/tb_pong_physics.sv
// tb_pong_physics: self-checking bench for pong_physics (TICK_DIV = 4).
// A behavioural model of the field (integer positions, signed velocities,
// cycle counts with modulo ticks) runs alongside the DUT; outputs are compared
// every cycle on the falling edge, plus directed checks on fixed expectations.
// Honours PONG_AI_P2_EN in the model when the build defines it.
module tb_pong_physics;
  localparam int TICK_DIV    = 4;
  localparam int PADDLE_STEP = 4;
  localparam int SPEED_MAX   = 3;
  localparam int M_SERVE     = 0;
  localparam int M_RUN       = 1;
  localparam int M_MISS      = 2;

  logic clk = 1'b0;
  logic rst;
  pong_physics_if bus ();

  pong_physics #(
    .TICK_DIV   (TICK_DIV),
    .PADDLE_STEP(PADDLE_STEP),
    .SPEED_MAX  (SPEED_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_mode, m_bx, m_by, m_vx, m_vy, m_p1, m_p2, m_lvl;
  int m_run_cycles, m_all_cycles;
  bit m_miss1, m_miss2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int paddle_move(input int y, input int dir);
    int t;
    t = y + dir * PADDLE_STEP;
    if (t < 0) t = 0;
    if (t > 416) t = 416;
    return t;
  endfunction

  task automatic model_reset();
    m_mode = M_SERVE;
    m_bx = 316; m_by = 236; m_vx = 1; m_vy = 1;
    m_p1 = 208; m_p2 = 208; m_lvl = 0;
    m_run_cycles = 0; m_all_cycles = 0;
    m_miss1 = 0; m_miss2 = 0;
  endtask

  // One clock edge of the game rules, applied to the inputs present at that edge.
  task automatic model_step();
    int s, nx, ny, old_by, old_p1, old_p2, dir1, dir2;
    bit run_tick, free_tick, pad_tick, hit1, hit2;
    old_by = m_by; old_p1 = m_p1; old_p2 = m_p2;
    m_all_cycles++;
    free_tick = (m_all_cycles % TICK_DIV) == 0;
    run_tick  = 0;
    if (m_mode == M_RUN && !bus.stop) begin
      m_run_cycles++;
      run_tick = (m_run_cycles % TICK_DIV) == 0;
    end
    pad_tick = (m_mode == M_RUN) ? run_tick : (m_mode == M_SERVE && free_tick);
    m_miss1 = 0; m_miss2 = 0;

    if (run_tick) begin
      s    = 1 + m_lvl;
      nx   = m_bx + m_vx * s;
      ny   = m_by + m_vy * s;
      hit1 = (m_by + 8 > old_p1) && (m_by < old_p1 + 64);
      hit2 = (m_by + 8 > old_p2) && (m_by < old_p2 + 64);
      if (ny <= 0) begin m_by = 0; m_vy = 1; end
      else if (ny >= 472) begin m_by = 472; m_vy = -1; end
      else m_by = ny;
      if (m_vx < 0 && m_bx >= 24 && nx < 24 && hit1) begin m_bx = 24; m_vx = 1; end
      else if (m_vx > 0 && m_bx <= 608 && nx > 608 && hit2) begin m_bx = 608; m_vx = -1; end
      else if (nx <= 0) begin m_bx = 0; m_miss1 = 1; m_mode = M_MISS; end
      else if (nx >= 632) begin m_bx = 632; m_miss2 = 1; m_mode = M_MISS; end
      else m_bx = nx;
    end else if (m_mode == M_MISS && bus.stop) begin
      m_vx = (m_bx == 0) ? -1 : 1;
      m_bx = 316; m_by = 236; m_mode = M_SERVE;
    end else if (m_mode == M_SERVE && !bus.stop) begin
      m_mode = M_RUN;
    end

    if (pad_tick) begin
      dir1 = (bus.up1 && !bus.down1) ? -1 : (bus.down1 && !bus.up1) ? 1 : 0;
`ifdef PONG_AI_P2_EN
      dir2 = (old_p2 > old_by - 28) ? -1 : (old_p2 < old_by - 28) ? 1 : 0;
`else
      dir2 = (bus.up2 && !bus.down2) ? -1 : (bus.down2 && !bus.up2) ? 1 : 0;
`endif
      m_p1 = paddle_move(old_p1, dir1);
      m_p2 = paddle_move(old_p2, dir2);
    end
    if (bus.speed_up && m_lvl < SPEED_MAX) m_lvl++;
  endtask

  task automatic compare_all();
    check("ball_x", 32'(bus.ball_x), m_bx);
    check("ball_y", 32'(bus.ball_y), m_by);
    check("paddle1_y", 32'(bus.paddle1_y), m_p1);
    check("paddle2_y", 32'(bus.paddle2_y), m_p2);
    check("miss1", 32'(bus.miss1), 32'(m_miss1));
    check("miss2", 32'(bus.miss2), 32'(m_miss2));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic random_keys();
    bus.up1   = 1'($urandom_range(0, 1));
    bus.down1 = 1'($urandom_range(0, 1));
    bus.up2   = 1'($urandom_range(0, 1));
    bus.down2 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen, left;
    int x0, y0;
    bus.stop = 1'b1; bus.up1 = 1'b0; bus.down1 = 1'b0;
    bus.up2 = 1'b0; bus.down2 = 1'b0; bus.speed_up = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    compare_all();

    // Serve held while stopped, then release play.
    rst = 1'b1;
    repeat (3) cycle();
    bus.stop = 1'b0;
    repeat (20) cycle();
    check("first_moves_x", 32'(bus.ball_x), 320);
    check("first_moves_y", 32'(bus.ball_y), 240);

    // Paddle 1 driven to the top, then down, then both keys cancel.
    bus.up1 = 1'b1;
    repeat (240) cycle();
    check("p1_top_clamp", 32'(bus.paddle1_y), 0);
    bus.up1 = 1'b0; bus.down1 = 1'b1;
    repeat (40) cycle();
    check("p1_down", 32'(bus.paddle1_y), 40);
    bus.up1 = 1'b1;
    repeat (20) cycle();
    check("p1_both_keys", 32'(bus.paddle1_y), 40);
    bus.up1 = 1'b0; bus.down1 = 1'b0;

    // Five speed_up pulses saturate at level 3: 4 px per tick.
    repeat (5) begin
      bus.speed_up = 1'b1; cycle();
      bus.speed_up = 1'b0; cycle();
    end
    x0 = int'(bus.ball_x); y0 = int'(bus.ball_y);
    repeat (TICK_DIV) cycle();
    check("speed_dx", 32'(int'(bus.ball_x) - x0), 4);
    check("speed_dy", 32'(int'(bus.ball_y) - y0), 4);

    // Play on with wandering paddles until somebody misses.
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      random_keys();
      cycle();
      if (bus.miss1 === 1'b1 || bus.miss2 === 1'b1) seen = 1;
    end
    check("miss_seen", 32'(seen), 1);
    if (seen) begin
      left = bus.miss1;
      check("miss_exclusive", 32'(bus.miss1) + 32'(bus.miss2), 1);
      check("miss_x", 32'(bus.ball_x), left ? 0 : 632);
      bus.up1 = 1'b0; bus.down1 = 1'b0; bus.up2 = 1'b0; bus.down2 = 1'b0;
      cycle();
      check("miss_pulse_len", 32'(bus.miss1 | bus.miss2), 0);
      check("miss_freeze_x", 32'(bus.ball_x), left ? 0 : 632);
      bus.stop = 1'b1;
      cycle();
      check("recentre_x", 32'(bus.ball_x), 316);
      check("recentre_y", 32'(bus.ball_y), 236);
      bus.stop = 1'b0;
      repeat (TICK_DIV + 1) cycle();
      check("serve_dir_x", 32'(bus.ball_x), left ? 312 : 320);
    end

    // Randomised play: keys, rare pauses, serves after misses.
    for (int i = 0; i < 8000; i++) begin
      random_keys();
      bus.speed_up = ($urandom_range(0, 99) == 0);
      case (m_mode)
        M_RUN:   bus.stop = ($urandom_range(0, 29) == 0);
        M_MISS:  bus.stop = ($urandom_range(0, 2) == 0);
        default: bus.stop = 1'($urandom_range(0, 1));
      endcase
      cycle();
    end
    bus.speed_up = 1'b0;

    // Asynchronous reset mid-play, away from any clock edge.
    bus.stop = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    bus.up1 = 1'b0; bus.down1 = 1'b0; bus.up2 = 1'b0; bus.down2 = 1'b0;
    repeat (2 * TICK_DIV + 1) cycle();
    check("post_reset_x", 32'(bus.ball_x), 318);
    check("post_reset_y", 32'(bus.ball_y), 238);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
